// File: rtl/cpu_sequencer.sv
// Boot/run controller for the 8-bit CPU core: byte-serial code load, timed reset
// release, then run/halt/single-step gating with a cycle-limit watchdog.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | core held in reset, waiting for load_start
// LOAD  | accepting code bytes, core held in reset
// BOOT  | image complete, reset held for BOOT_CYCLES cycles
// HALT  | core out of reset, clock enable off (single-step allowed)
// RUN   | core free-running until halt, reload or watchdog
module cpu_sequencer #(
  parameter int CODE_SZ     = 256,
  parameter int BOOT_CYCLES = 2,
  parameter int CYC_SZ      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_start,
  input  logic [7:0]         in_data,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               cmd_run,
  input  logic               cmd_halt,
  input  logic               cmd_step,
  input  logic [CYC_SZ-1:0]  cycle_limit,
  output logic [CODE_SZ-1:0] code,
  output logic               cpu_reset,
  output logic               cpu_en,
  output logic [2:0]         state,
  output logic [CYC_SZ-1:0]  cycles,
  output logic               limit_hit
);

  localparam int NBYTES = CODE_SZ / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BW     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
  localparam logic [BW-1:0]    BOOT_INIT = BW'(BOOT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_BOOT = 3'd2,
    S_HALT = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t            st;
  logic [CNT_W-1:0]  byte_cnt;
  logic [BW-1:0]     boot_cnt;
  logic [CYC_SZ-1:0] cycles_inc;
  logic              limit_on;
  logic              at_limit;
  logic              hit;
  logic              blocked;

  assign in_ready = (st == S_LOAD);
  assign state    = st;

  // hit fires only on the edge where the count actually arrives at the limit,
  // so a saturated counter sitting on the limit does not retrigger.
  assign cycles_inc = (cycles == '1) ? cycles : cycles + 1'b1;
  assign limit_on   = (cycle_limit != '0);
  assign at_limit   = limit_on && (cycles >= cycle_limit);
  assign hit        = cpu_en && limit_on && (cycles != cycle_limit) &&
                      (cycles_inc == cycle_limit);
  assign blocked    = at_limit || hit;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= S_IDLE;
      code      <= '0;
      byte_cnt  <= '0;
      boot_cnt  <= '0;
      cpu_reset <= 1'b1;
      cpu_en    <= 1'b0;
      cycles    <= '0;
      limit_hit <= 1'b0;
    end else begin
      if (cpu_en) cycles <= cycles_inc;
      if (hit) limit_hit <= 1'b1;

      case (st)
        S_IDLE: begin
          cpu_reset <= 1'b1;
          cpu_en    <= 1'b0;
          if (load_start) begin
            st        <= S_LOAD;
            byte_cnt  <= '0;
            limit_hit <= 1'b0;
          end
        end

        S_LOAD: begin
          if (in_valid) begin
            code[8*int'(byte_cnt) +: 8] <= in_data;
            if (byte_cnt == LAST_BYTE) begin
              st       <= S_BOOT;
              boot_cnt <= BOOT_INIT;
              cycles   <= '0;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end

        S_BOOT: begin
          if (boot_cnt == '0) begin
            st        <= S_HALT;
            cpu_reset <= 1'b0;
          end else begin
            boot_cnt <= boot_cnt - 1'b1;
          end
        end

        S_HALT: begin
          if (load_start) begin
            st        <= S_LOAD;
            cpu_reset <= 1'b1;
            cpu_en    <= 1'b0;
            byte_cnt  <= '0;
            limit_hit <= 1'b0;
          end else if (cmd_halt) begin
            cpu_en <= 1'b0;
          end else if (cmd_run && !blocked) begin
            st     <= S_RUN;
            cpu_en <= 1'b1;
          end else if (cmd_step && !cpu_en && !blocked) begin
            // a step pulse never samples a new step, so a held step toggles
            cpu_en <= 1'b1;
          end else begin
            cpu_en <= 1'b0;
          end
        end

        S_RUN: begin
          if (cmd_halt) begin
            st     <= S_HALT;
            cpu_en <= 1'b0;
          end else if (load_start) begin
            st        <= S_LOAD;
            cpu_reset <= 1'b1;
            cpu_en    <= 1'b0;
            byte_cnt  <= '0;
            limit_hit <= 1'b0;
          end else if (hit) begin
            st     <= S_HALT;
            cpu_en <= 1'b0;
          end
        end

        default: begin
          st        <= S_IDLE;
          cpu_reset <= 1'b1;
          cpu_en    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: table-driven command vectors plus hand-written
// load, boot, watchdog and asynchronous reset sequences.
module tb_cpu_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         load_start;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic         cmd_run;
  logic         cmd_halt;
  logic         cmd_step;
  logic [15:0]  cycle_limit;
  logic [255:0] code;
  logic         cpu_reset;
  logic         cpu_en;
  logic [2:0]   state;
  logic [15:0]  cycles;
  logic         limit_hit;

  int checks = 0;
  int errors = 0;
  logic [255:0] exp_code;

  cpu_sequencer #(.CODE_SZ(256), .BOOT_CYCLES(2), .CYC_SZ(16)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .cmd_run(cmd_run),
    .cmd_halt(cmd_halt), .cmd_step(cmd_step), .cycle_limit(cycle_limit),
    .code(code), .cpu_reset(cpu_reset), .cpu_en(cpu_en), .state(state),
    .cycles(cycles), .limit_hit(limit_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld, run, halt, step;
    logic [15:0] lim;
    logic [2:0]  st;
    logic        en, rst;
    logic [15:0] cyc;
    logic        lh;
  } vec_t;

  vec_t vec_a[8];
  vec_t vec_b[7];
  vec_t vec_c[8];

  function automatic vec_t mk(input logic ld, input logic run, input logic halt,
                              input logic step, input logic [15:0] lim,
                              input logic [2:0] st, input logic en, input logic rst,
                              input logic [15:0] cyc, input logic lh);
    vec_t v;
    v.ld = ld; v.run = run; v.halt = halt; v.step = step; v.lim = lim;
    v.st = st; v.en = en; v.rst = rst; v.cyc = cyc; v.lh = lh;
    return v;
  endfunction

  function automatic logic [7:0] byte_fn(input int seed, input int idx);
    return (seed == 0) ? 8'(idx) : 8'(idx * 7 + seed);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int i);
    string n;
    load_start = v.ld; cmd_run = v.run; cmd_halt = v.halt; cmd_step = v.step;
    cycle_limit = v.lim;
    tick();
    n = $sformatf("%s[%0d]", tag, i);
    check({n, ".state"},     256'(state),     256'(v.st));
    check({n, ".cpu_en"},    256'(cpu_en),    256'(v.en));
    check({n, ".cpu_reset"}, 256'(cpu_reset), 256'(v.rst));
    check({n, ".cycles"},    256'(cycles),    256'(v.cyc));
    check({n, ".limit_hit"}, 256'(limit_hit), 256'(v.lh));
  endtask

  // Full load from IDLE or HALT; toggle=1 drives in_valid 1/0 on alternate cycles.
  task automatic load_img(input bit toggle, input int seed, input string tag);
    int n;
    int rdy;
    int idx;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check({tag, ".enter_state"}, 256'(state), 256'(3'd1));
    check({tag, ".enter_rst"},   256'(cpu_reset), 256'(1'b1));
    check({tag, ".enter_lh"},    256'(limit_hit), 256'(1'b0));
    n   = toggle ? 63 : 32;
    rdy = 0;
    for (int i = 0; i < n; i++) begin
      idx      = toggle ? i / 2 : i;
      in_valid = toggle ? ((i % 2) == 0) : 1'b1;
      in_data  = byte_fn(seed, idx);
      if (in_valid) exp_code[idx*8 +: 8] = in_data;
      if (in_ready) rdy++;
      tick();
    end
    in_valid = 1'b0;
    check({tag, ".ready_cycles"}, 256'(rdy), 256'(n));
    check({tag, ".boot_state"},   256'(state), 256'(3'd2));
    check({tag, ".ready_after"},  256'(in_ready), 256'(1'b0));
    check({tag, ".boot_rst0"},    256'(cpu_reset), 256'(1'b1));
    tick();
    check({tag, ".boot_rst1"},    256'(cpu_reset), 256'(1'b1));
    tick();
    check({tag, ".halt_state"},   256'(state), 256'(3'd3));
    check({tag, ".halt_rst"},     256'(cpu_reset), 256'(1'b0));
    check({tag, ".halt_cycles"},  256'(cycles), 256'(16'd0));
    check({tag, ".code"},         code, exp_code);
  endtask

  initial begin
    int cnt;

    // HALT, cycles 0, no limit: three step pulses including a held step
    vec_a[0] = mk(0,0,0,1, 16'd0, 3'd3, 1, 0, 16'd0, 0);
    vec_a[1] = mk(0,0,0,0, 16'd0, 3'd3, 0, 0, 16'd1, 0);
    vec_a[2] = mk(0,0,0,1, 16'd0, 3'd3, 1, 0, 16'd1, 0);
    vec_a[3] = mk(0,0,0,1, 16'd0, 3'd3, 0, 0, 16'd2, 0);
    vec_a[4] = mk(0,0,0,1, 16'd0, 3'd3, 1, 0, 16'd2, 0);
    vec_a[5] = mk(0,0,0,0, 16'd0, 3'd3, 0, 0, 16'd3, 0);
    vec_a[6] = mk(0,0,1,0, 16'd0, 3'd3, 0, 0, 16'd3, 0);
    vec_a[7] = mk(0,1,1,0, 16'd0, 3'd3, 0, 0, 16'd3, 0);
    // after watchdog at 10: blocked, then limit cleared, run, halt beats load
    vec_b[0] = mk(0,1,0,0, 16'd10, 3'd3, 0, 0, 16'd10, 1);
    vec_b[1] = mk(0,0,0,1, 16'd10, 3'd3, 0, 0, 16'd10, 1);
    vec_b[2] = mk(0,0,0,0, 16'd0,  3'd3, 0, 0, 16'd10, 1);
    vec_b[3] = mk(0,1,0,0, 16'd0,  3'd4, 1, 0, 16'd10, 1);
    vec_b[4] = mk(0,0,0,0, 16'd0,  3'd4, 1, 0, 16'd11, 1);
    vec_b[5] = mk(1,0,1,0, 16'd0,  3'd3, 0, 0, 16'd12, 1);
    vec_b[6] = mk(1,0,0,0, 16'd0,  3'd1, 0, 1, 16'd12, 0);
    // watchdog reached via steps, then raised limit re-enables run
    vec_c[0] = mk(0,0,0,1, 16'd2, 3'd3, 1, 0, 16'd0, 0);
    vec_c[1] = mk(0,0,0,0, 16'd2, 3'd3, 0, 0, 16'd1, 0);
    vec_c[2] = mk(0,0,0,1, 16'd2, 3'd3, 1, 0, 16'd1, 0);
    vec_c[3] = mk(0,0,0,0, 16'd2, 3'd3, 0, 0, 16'd2, 1);
    vec_c[4] = mk(0,0,0,1, 16'd2, 3'd3, 0, 0, 16'd2, 1);
    vec_c[5] = mk(0,1,0,0, 16'd2, 3'd3, 0, 0, 16'd2, 1);
    vec_c[6] = mk(0,1,0,0, 16'd3, 3'd4, 1, 0, 16'd2, 1);
    vec_c[7] = mk(0,0,0,0, 16'd3, 3'd3, 0, 0, 16'd3, 1);

    reset = 1'b0; load_start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    cmd_run = 1'b0; cmd_halt = 1'b0; cmd_step = 1'b0; cycle_limit = 16'd0;
    exp_code = '0;
    tick();
    tick();
    check("rst.state",     256'(state), 256'(3'd0));
    check("rst.code",      code, 256'(0));
    check("rst.cpu_reset", 256'(cpu_reset), 256'(1'b1));
    check("rst.cpu_en",    256'(cpu_en), 256'(1'b0));
    check("rst.cycles",    256'(cycles), 256'(16'd0));
    check("rst.limit_hit", 256'(limit_hit), 256'(1'b0));
    check("rst.in_ready",  256'(in_ready), 256'(1'b0));
    reset = 1'b1;
    cmd_run = 1'b1; cmd_step = 1'b1;
    tick();
    check("idle.ignores_cmd", 256'(state), 256'(3'd0));
    cmd_run = 1'b0; cmd_step = 1'b0;

    load_img(1'b0, 0, "load_held");
    check("load_held.lo_byte", 256'(code[7:0]), 256'(8'h00));
    check("load_held.hi_byte", 256'(code[255:248]), 256'(8'h1F));

    for (int i = 0; i < 8; i++) apply_vec(vec_a[i], "step", i);
    cmd_run = 1'b0; cmd_halt = 1'b0;

    load_img(1'b1, 5, "load_toggle");

    cycle_limit = 16'd10;
    cmd_run = 1'b1;
    tick();
    cmd_run = 1'b0;
    cnt = cpu_en ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_en) cnt++;
    end
    check("wdog.en_cycles", 256'(cnt), 256'(10));
    check("wdog.state",     256'(state), 256'(3'd3));
    check("wdog.cycles",    256'(cycles), 256'(16'd10));
    check("wdog.limit_hit", 256'(limit_hit), 256'(1'b1));

    for (int i = 0; i < 7; i++) apply_vec(vec_b[i], "limit", i);
    load_start = 1'b0;

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'h55 + i);
      tick();
    end
    in_valid = 1'b0;
    check("midload.state", 256'(state), 256'(3'd1));
    #2;
    reset = 1'b0;
    #1;
    exp_code = '0;
    check("async.code",      code, 256'(0));
    check("async.state",     256'(state), 256'(3'd0));
    check("async.cpu_reset", 256'(cpu_reset), 256'(1'b1));
    check("async.in_ready",  256'(in_ready), 256'(1'b0));
    check("async.cycles",    256'(cycles), 256'(16'd0));
    tick();
    reset = 1'b1;
    tick();

    load_img(1'b0, 3, "reload");

    for (int i = 0; i < 8; i++) apply_vec(vec_c[i], "steplim", i);
    cmd_run = 1'b0; cmd_step = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
- Boot/run controller for the 8-bit CPU core.
- Loads the 256-bit code image from a byte-serial valid/ready stream and holds the core in reset during load.
- Releases reset after a fixed boot window, then gates core execution through a clock enable: run, halt, single-step, and a cycle-limit watchdog.
- Sits between the host/test harness and the CPU core: drives the core's code, reset and enable inputs.

Parameters:
- CODE_SZ, 256, code image width in bits; must be a multiple of 8.
- BOOT_CYCLES, 2, number of cycles cpu_reset stays high in BOOT, minimum 1.
- CYC_SZ, 16, width of the executed-cycle counter and the limit.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- load_start  in  1  request (re)load of the code image.
- in_data  in  8  code byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  sequencer accepts a byte this cycle.
- cmd_run  in  1  start free-running execution.
- cmd_halt  in  1  stop execution.
- cmd_step  in  1  execute exactly one core cycle.
- cycle_limit  in  CYC_SZ  watchdog limit; 0 = unlimited.
- code  out  CODE_SZ  code image to the core.
- cpu_reset  out  1  active-high reset to the core.
- cpu_en  out  1  core clock enable.
- state  out  3  current state encoding.
- cycles  out  CYC_SZ  core cycles executed since boot.
- limit_hit  out  1  sticky: watchdog stopped the core.

Behaviour:
- All outputs are registered except in_ready.
- in_ready = (state == LOAD); it is combinational from the state register.
- Reset (reset=0, asynchronous):
  - state = IDLE, code = 0, byte count = 0.
  - cpu_reset = 1, cpu_en = 0, cycles = 0, limit_hit = 0.
  - Reset asserted mid-load or mid-run discards everything, including partial code.
- State encoding: IDLE=0, LOAD=1, BOOT=2, HALT=3, RUN=4.
- IDLE:
  - cpu_reset=1.
  - load_start -> LOAD; byte count cleared, limit_hit cleared.
  - All cmd_* inputs are ignored.
- LOAD:
  - cpu_reset=1.
  - A byte is accepted on each edge where in_valid && in_ready.
  - Byte k (k = 0..CODE_SZ/8-1) is written to code[8k+7:8k]; byte 0 is the lowest address.
  - Unwritten bytes keep their previous values.
  - On acceptance of the last byte (k = CODE_SZ/8-1) -> BOOT. in_ready is 0 from the next cycle on.
  - in_valid=0 stalls the load indefinitely with no timeout.
  - load_start and cmd_* are ignored.
- BOOT:
  - cpu_reset=1 for exactly BOOT_CYCLES cycles, then -> HALT.
  - cycles is cleared on entry.
- HALT:
  - cpu_reset=0, cpu_en=0.
  - Input priority: load_start > cmd_halt > cmd_run > cmd_step.
  - load_start -> LOAD; cpu_reset=1 from the next cycle; byte count cleared; limit_hit cleared.
  - cmd_halt: no effect.
  - cmd_run -> RUN; cpu_en=1 from the next cycle.
  - cmd_step: cpu_en=1 for exactly one cycle, then 0; state stays HALT.
  - cmd_step held high steps every other cycle: an edge where cpu_en=1 does not sample a step.
- RUN:
  - cpu_en=1 every cycle.
  - cmd_halt (priority over load_start in RUN) -> HALT; cpu_en=0 after that edge.
  - load_start in RUN -> LOAD; cpu_en=0, cpu_reset=1.
  - cmd_run and cmd_step are ignored.
- Cycle count:
  - cycles increments on each edge where cpu_en=1.
  - It saturates at all-ones and never wraps.
- Watchdog (cycle_limit != 0):
  - On the edge where cycles becomes equal to cycle_limit, cpu_en is forced to 0, state goes to HALT, and limit_hit is set.
  - While cycles >= cycle_limit, cmd_run and cmd_step are ignored.
  - Raising cycle_limit (or setting it to 0) re-enables run/step; limit_hit stays set until the next load_start.
  - cycle_limit is sampled live every cycle.
- Simultaneous events:
  - cmd_halt together with the limit edge -> HALT, limit_hit=1.
  - A limit reached via a step behaves the same as in RUN.

Test Plan:
- Reset, load_start, 32 bytes 0x00..0x1F with in_valid held high -> in_ready high for 32 cycles; code[7:0]=0x00 and code[255:248]=0x1F; cpu_reset falls exactly 2 cycles after BOOT entry; state=HALT.
- Load with in_valid toggling 1/0 every cycle -> 32 accepted bytes over 63 cycles; image correct; no byte duplicated or dropped.
- HALT, cmd_step pulsed 3 times -> three single-cycle cpu_en pulses; cycles=3; state stays 3.
- cycle_limit=10, cmd_run -> cpu_en high exactly 10 cycles; state=HALT; limit_hit=1; further cmd_run ignored. Set cycle_limit=0, then cmd_run -> RUN resumes.
- RUN with load_start and cmd_halt asserted in the same cycle -> HALT; no load. Next load_start -> LOAD; cpu_reset=1; limit_hit=0.
- Drive reset=0 asynchronously mid-LOAD after 5 bytes -> code=0 and state=IDLE immediately. A new full load then boots normally.
